acc_dump_ctrl: RTL and testbench

- Readout end of the correlator accumulator bank.
- On a dump request, takes a single-edge snapshot of the I/Q accumulators of all CORR_NUM correlator channels, and pulses acc_clear so the accumulators start a new integration on the same edge.
- Streams the snapshot, one channel per transfer, to the result buffer over a valid/ready interface.
- Sits between the data_acc array and the measurement/result memory writer.

---
 rtl/acc_dump_ctrl_pkg.sv | 22 ++
 rtl/acc_dump_ctrl_if.sv | 25 ++
 rtl/acc_dump_ctrl.sv | 110 +++++++++++
 tb/tb_acc_dump_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_dump_ctrl_pkg.sv
// Shared correlator definitions for the accumulator bank and its readout.
// Bus packing helpers are also used by the data_acc array wrapper.
package acc_dump_ctrl_pkg;

  localparam int ACC_DATA_WIDTH_DEF = 16;
  localparam int CORR_NUM_DEF       = 8;
  localparam int IDX_WIDTH_DEF      = 3;

  // One readout beat carries an I lane and a Q lane.
  localparam int IQ_LANES = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dump_state_t;

  // Lowest bit of channel ch in a flat accumulator bus of w-bit lanes.
  function automatic int acc_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/acc_dump_ctrl_if.sv
// Valid/ready readout stream: one correlator channel {I, Q} per beat.
interface acc_dump_if
  import acc_dump_ctrl_pkg::*;
#(
  parameter int ACC_DATA_WIDTH = ACC_DATA_WIDTH_DEF,
  parameter int IDX_WIDTH      = IDX_WIDTH_DEF
) ();

  logic                               out_valid;
  logic                               out_ready;
  logic [IQ_LANES*ACC_DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]               out_index;
  logic                               out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/acc_dump_ctrl.sv
// Snapshots all correlator I/Q accumulators on dump_req and streams them out one channel per beat.
// First beat is valid the cycle after dump_req; beats hold stable under backpressure.
module acc_dump_ctrl
  import acc_dump_ctrl_pkg::*;
#(
  parameter int ACC_DATA_WIDTH = ACC_DATA_WIDTH_DEF,
  parameter int CORR_NUM       = CORR_NUM_DEF,
  parameter int IDX_WIDTH      = IDX_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               dump_req,
  input  logic [CORR_NUM*ACC_DATA_WIDTH-1:0] i_acc_bus,
  input  logic [CORR_NUM*ACC_DATA_WIDTH-1:0] q_acc_bus,
  output logic                               acc_clear,
  output logic                               busy,
  output logic                               overrun,
  input  logic                               overrun_clr,
  acc_dump_if.master                         out_if
);

  localparam int W = ACC_DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CORR_NUM - 1);

  dump_state_t               r_state;
  logic [IDX_WIDTH-1:0]      r_idx;
  logic [W-1:0]              r_shadow_i [CORR_NUM];
  logic [W-1:0]              r_shadow_q [CORR_NUM];
  logic [IQ_LANES*W-1:0]     r_data;
  logic                      r_valid;
  logic                      r_last;
  logic                      r_busy;
  logic                      r_overrun;

  logic                      w_fire;
  logic                      w_final;
  logic                      w_capture;
  logic                      w_lost;
  logic [IDX_WIDTH-1:0]      w_idx_nxt;

  assign w_fire    = r_valid & out_if.out_ready;
  assign w_final   = w_fire & r_last;
  // A dump is taken when idle or when the last beat leaves on the same edge.
  assign w_capture = dump_req & ((r_state == ST_IDLE) | w_final);
  assign w_lost    = dump_req & (r_state == ST_SEND) & ~w_final;
  assign w_idx_nxt = r_idx + IDX_WIDTH'(1);

  // The accumulators must restart on every boundary, even when the snapshot is dropped.
  assign acc_clear = dump_req;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < CORR_NUM; k++) begin
        r_shadow_i[k] <= '0;
        r_shadow_q[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < CORR_NUM; k++) begin
        r_shadow_i[k] <= i_acc_bus[acc_lsb(k, W) +: W];
        r_shadow_q[k] <= q_acc_bus[acc_lsb(k, W) +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_capture) begin
      // Beat 0 comes straight from the bus so it is valid the cycle after the dump.
      r_state <= ST_SEND;
      r_idx   <= '0;
      r_data  <= {i_acc_bus[W-1:0], q_acc_bus[W-1:0]};
      r_valid <= 1'b1;
      r_last  <= 1'b0;
      r_busy  <= 1'b1;
    end else if (w_final) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_fire) begin
      r_idx   <= w_idx_nxt;
      r_data  <= {r_shadow_i[w_idx_nxt], r_shadow_q[w_idx_nxt]};
      r_last  <= (w_idx_nxt == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overrun <= 1'b0;
    end else if (w_lost) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_data;
  assign out_if.out_index = r_idx;
  assign out_if.out_last  = r_last;
  assign busy             = r_busy;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_acc_dump_ctrl.sv
// Directed and randomised checks of acc_dump_ctrl; all stimulus changes and samples happen at negedge.
module tb_acc_dump_ctrl;
  import acc_dump_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst_b = 1'b0;
  logic           dump_req = 1'b0;
  logic           overrun_clr = 1'b0;
  logic [N*W-1:0] i_acc_bus = '0;
  logic [N*W-1:0] q_acc_bus = '0;
  logic           acc_clear;
  logic           busy;
  logic           overrun;

  acc_dump_if #(.ACC_DATA_WIDTH(W), .IDX_WIDTH(IW)) u_if ();

  acc_dump_ctrl #(.ACC_DATA_WIDTH(W), .CORR_NUM(N), .IDX_WIDTH(IW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .dump_req    (dump_req),
    .i_acc_bus   (i_acc_bus),
    .q_acc_bus   (q_acc_bus),
    .acc_clear   (acc_clear),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .out_if      (u_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_beats = 0;

  logic [W-1:0] bi [N];
  logic [W-1:0] bq [N];
  logic [W-1:0] ei [N];
  logic [W-1:0] eq [N];

  always @(posedge clk) if (u_if.out_valid && u_if.out_ready) n_beats <= n_beats + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pack_bus();
    for (int k = 0; k < N; k++) begin
      i_acc_bus[k*W +: W] = bi[k];
      q_acc_bus[k*W +: W] = bq[k];
    end
  endtask

  task automatic load_pat(input int p);
    for (int k = 0; k < N; k++) begin
      case (p)
        0:       begin bi[k] = 16'(k + 1);          bq[k] = 16'(-(k + 1));        end
        1:       begin bi[k] = 16'h0100 + 16'(k);   bq[k] = 16'h0200 + 16'(k);    end
        2:       begin bi[k] = 16'h8000 + 16'(k);   bq[k] = 16'h7FF0 - 16'(k);    end
        3:       begin bi[k] = 16'hA5A5;            bq[k] = 16'h5A5A ^ 16'(k);    end
        default: begin bi[k] = 16'h7FFF;            bq[k] = 16'h8000;             end
      endcase
    end
    pack_bus();
  endtask

  task automatic latch_exp();
    for (int k = 0; k < N; k++) begin
      ei[k] = bi[k];
      eq[k] = bq[k];
    end
  endtask

  task automatic chk_beat(input int k);
    check_val($sformatf("b%0d_valid", k), 64'(u_if.out_valid), 64'(1));
    check_val($sformatf("b%0d_index", k), 64'(u_if.out_index), 64'(k));
    check_val($sformatf("b%0d_data", k),  64'(u_if.out_data),  64'({ei[k], eq[k]}));
    check_val($sformatf("b%0d_last", k),  64'(u_if.out_last),  64'(k == N - 1));
    check_val($sformatf("b%0d_busy", k),  64'(busy),           64'(1));
  endtask

  // Entered just after a negedge; leaves just after the negedge where beat 0 is visible.
  task automatic start_dump(input int p);
    load_pat(p);
    latch_exp();
    dump_req = 1'b1;
    #1 check_val("acc_clear", 64'(acc_clear), 64'(1));
    @(negedge clk);
    dump_req = 1'b0;
    load_pat(3);
  endtask

  task automatic run_beats(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      chk_beat(k);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    u_if.out_ready = 1'b1;
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    check_val("drain_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    logic m_send, m_ovr, fire, fin, d, r, c;
    int m_idx;
    logic [W-1:0] ms_i [N];
    logic [W-1:0] ms_q [N];

    u_if.out_ready = 1'b0;
    #2;
    check_val("rst_valid",   64'(u_if.out_valid), 64'(0));
    check_val("rst_last",    64'(u_if.out_last),  64'(0));
    check_val("rst_index",   64'(u_if.out_index), 64'(0));
    check_val("rst_data",    64'(u_if.out_data),  64'(0));
    check_val("rst_busy",    64'(busy),           64'(0));
    check_val("rst_overrun", 64'(overrun),        64'(0));
    check_val("rst_clear",   64'(acc_clear),      64'(0));
    @(negedge clk);
    rst_b = 1'b1;
    u_if.out_ready = 1'b1;
    @(negedge clk);

    // 1: basic readout, I=k+1, Q=-(k+1)
    check_val("t1_idle_busy", 64'(busy), 64'(0));
    start_dump(0);
    check_val("t1_first_data", 64'(u_if.out_data), 64'(32'h0001FFFF));
    run_beats(0, 6);
    check_val("t1_last_data", 64'(u_if.out_data), 64'(32'h0008FFF8));
    run_beats(7, 7);
    check_val("t1_done_busy",  64'(busy),           64'(0));
    check_val("t1_done_valid", 64'(u_if.out_valid), 64'(0));

    // 2: backpressure at index 3
    b0 = n_beats;
    start_dump(1);
    run_beats(0, 2);
    chk_beat(3);
    u_if.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_beat(3);
    end
    u_if.out_ready = 1'b1;
    run_beats(3, 7);
    check_val("t2_beat_count", 64'(n_beats - b0), 64'(8));
    check_val("t2_done_busy",  64'(busy),         64'(0));

    // 3: lost dump at index 2, then set/clear collision
    start_dump(2);
    run_beats(0, 1);
    chk_beat(2);
    dump_req = 1'b1;
    load_pat(4);
    #1 check_val("t3_clear", 64'(acc_clear), 64'(1));
    @(negedge clk);
    dump_req = 1'b0;
    check_val("t3_overrun", 64'(overrun), 64'(1));
    run_beats(3, 7);
    check_val("t3_sticky", 64'(overrun), 64'(1));
    check_val("t3_idle",   64'(busy),    64'(0));
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check_val("t3_cleared", 64'(overrun), 64'(0));
    start_dump(1);
    run_beats(0, 0);
    dump_req = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    overrun_clr = 1'b0;
    check_val("t3_set_wins", 64'(overrun), 64'(1));
    run_beats(2, 7);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check_val("t3_cleared2", 64'(overrun), 64'(0));

    // 4: dump coincident with final beat
    start_dump(0);
    run_beats(0, 6);
    chk_beat(7);
    dump_req = 1'b1;
    load_pat(4);
    latch_exp();
    #1 check_val("t4_clear", 64'(acc_clear), 64'(1));
    @(negedge clk);
    dump_req = 1'b0;
    load_pat(3);
    check_val("t4_valid",   64'(u_if.out_valid), 64'(1));
    check_val("t4_index",   64'(u_if.out_index), 64'(0));
    check_val("t4_data",    64'(u_if.out_data),  64'(32'h7FFF8000));
    check_val("t4_last",    64'(u_if.out_last),  64'(0));
    check_val("t4_overrun", 64'(overrun),        64'(0));
    run_beats(0, 7);
    check_val("t4_overrun_end", 64'(overrun), 64'(0));

    // 5: reset mid-readout with overrun pending
    start_dump(1);
    run_beats(0, 1);
    chk_beat(2);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    check_val("t5_overrun", 64'(overrun), 64'(1));
    run_beats(3, 3);
    chk_beat(4);
    rst_b = 1'b0;
    #1;
    check_val("t5_valid",   64'(u_if.out_valid), 64'(0));
    check_val("t5_index",   64'(u_if.out_index), 64'(0));
    check_val("t5_data",    64'(u_if.out_data),  64'(0));
    check_val("t5_last",    64'(u_if.out_last),  64'(0));
    check_val("t5_busy",    64'(busy),           64'(0));
    check_val("t5_overrun", 64'(overrun),        64'(0));
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_val("t5_idle", 64'(busy), 64'(0));
    start_dump(2);
    run_beats(0, 7);
    check_val("t5_no_overrun", 64'(overrun), 64'(0));

    // 6: random dump/ready/clear against a behavioural model
    m_send = 1'b0;
    m_ovr  = 1'b0;
    m_idx  = 0;
    for (int k = 0; k < N; k++) begin
      ms_i[k] = '0;
      ms_q[k] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      check_val("rnd_valid",   64'(u_if.out_valid), 64'(m_send));
      check_val("rnd_busy",    64'(busy),           64'(m_send));
      check_val("rnd_overrun", 64'(overrun),        64'(m_ovr));
      if (m_send) begin
        check_val("rnd_index", 64'(u_if.out_index), 64'(m_idx));
        check_val("rnd_data",  64'(u_if.out_data),  64'({ms_i[m_idx], ms_q[m_idx]}));
        check_val("rnd_last",  64'(u_if.out_last),  64'(m_idx == N - 1));
      end
      for (int k = 0; k < N; k++) begin
        bi[k] = 16'($urandom);
        bq[k] = 16'($urandom);
      end
      pack_bus();
      d = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 15) == 0);
      dump_req = d;
      u_if.out_ready = r;
      overrun_clr = c;
      #1 check_val("rnd_clear", 64'(acc_clear), 64'(d));
      fire = m_send && r;
      fin  = fire && (m_idx == N - 1);
      if (d && m_send && !fin) m_ovr = 1'b1;
      else if (c)              m_ovr = 1'b0;
      if (d && (!m_send || fin)) begin
        for (int k = 0; k < N; k++) begin
          ms_i[k] = bi[k];
          ms_q[k] = bq[k];
        end
        m_idx  = 0;
        m_send = 1'b1;
      end else if (fin) begin
        m_send = 1'b0;
      end else if (fire) begin
        m_idx++;
      end
      @(negedge clk);
    end
    dump_req = 1'b0;
    overrun_clr = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
